// File: rtl/quiz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quiz_pkg
//  Description : Shared opcodes, answer width and FSM state encoding for the
//                quiz expression generator.
//  Revision    : 1.0  initial release
// ============================================================================
package quiz_pkg;

  // Operator codes as shown on the display, in LFSR op-field order
  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  // Largest possible answer is 9*9 = 81, which fits in 7 bits
  localparam int ANS_W = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CHECK = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Map the 2-bit op field (0 add, 1 sub, 2 mul, 3 div) to its display code
  function automatic logic [3:0] op_code(input logic [1:0] op);
    return OP_ADD + {2'b00, op};
  endfunction

endpackage
`default_nettype wire

// File: rtl/quiz_expr_gen_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit right-shifting Galois LFSR that advances only when
//                enabled. A zero seed is replaced by 1 to avoid lock-up.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  localparam logic [15:0] c_seed = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_q;
  logic [15:0] w_next;

  assign w_next = r_q[0] ? ((r_q >> 1) ^ TAPS) : (r_q >> 1);

  // Shift register: load seed on reset, step once per enabled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= c_seed;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/quiz_expr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : quiz_expr_gen
//  Description : Draws random arithmetic quiz expressions {A, op, B} from an
//                LFSR, rejects disabled/inexact/repeated candidates, falls
//                back to addition after a bounded number of retries, and
//                presents the result to the consumer with a req/ack handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module quiz_expr_gen
  import quiz_pkg::*;
#(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter logic [15:0] TAPS        = 16'hB400,
  parameter int          MAX_OPERAND = 9,
  parameter logic [3:0]  OP_MASK     = 4'b1111,
  parameter int          LINES       = 3,
  parameter int          MAX_RETRY   = 15,
  parameter bit          NO_REPEAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             ack,
  output logic             valid,
  output logic             busy,
  output logic [11:0]      exp,
  output logic [1:0]       line,
  output logic [ANS_W-1:0] answer,
  output logic             fallback
);

  localparam logic [5:0] c_max_op    = 6'(MAX_OPERAND);
  localparam logic [2:0] c_lines     = 3'(LINES);
  localparam logic [7:0] c_max_retry = 8'(MAX_RETRY);

  state_t           r_state;
  logic             r_valid;
  logic             r_busy;
  logic [11:0]      r_exp;
  logic [1:0]       r_line;
  logic [ANS_W-1:0] r_answer;
  logic             r_fallback;
  logic [7:0]       r_retry;
  logic [11:0]      r_last;

  logic [15:0]      w_lfsr;
  logic             w_adv;

  // The LFSR is frozen outside DRAW, so during CHECK it still holds the
  // post-advance value the candidate is derived from.
  assign w_adv = (r_state == S_DRAW);

  lfsr16 #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (w_adv),
    .q   (w_lfsr)
  );

  logic [5:0]       w_a6;
  logic [5:0]       w_b6;
  logic [2:0]       w_ln3;
  logic [3:0]       w_a;
  logic [3:0]       w_b;
  logic [1:0]       w_op;
  logic [1:0]       w_ln;
  logic             w_swap;
  logic [3:0]       w_x;
  logic [3:0]       w_y;
  logic [ANS_W-1:0] w_x7;
  logic [ANS_W-1:0] w_y7;
  logic [ANS_W-1:0] w_ans;
  logic [3:0]       w_rem;
  logic [11:0]      w_exp;
  logic             w_reject;
  logic [11:0]      w_fb_exp;
  logic [ANS_W-1:0] w_fb_ans;

  // Candidate fields from the current LFSR value
  assign w_a6  = (w_lfsr[5:0]  % c_max_op) + 6'd1;
  assign w_b6  = (w_lfsr[11:6] % c_max_op) + 6'd1;
  assign w_ln3 = {1'b0, w_lfsr[15:14]} % c_lines;
  assign w_a   = w_a6[3:0];
  assign w_b   = w_b6[3:0];
  assign w_op  = w_lfsr[13:12];
  assign w_ln  = w_ln3[1:0];

  // Subtraction with a<b swaps operands so the answer is never negative
  assign w_swap = (w_op == 2'd1) && (w_a < w_b);
  assign w_x    = w_swap ? w_b : w_a;
  assign w_y    = w_swap ? w_a : w_b;
  assign w_x7   = {3'b000, w_x};
  assign w_y7   = {3'b000, w_y};

  // Exact answer for the (possibly swapped) candidate
  always_comb begin
    w_ans = '0;
    case (w_op)
      2'd0:    w_ans = w_x7 + w_y7;
      2'd1:    w_ans = w_x7 - w_y7;
      2'd2:    w_ans = w_x7 * w_y7;
      default: w_ans = w_x7 / w_y7;
    endcase
  end

  // b is always at least 1, so the remainder never divides by zero
  assign w_rem    = w_a % w_b;
  assign w_exp    = {w_x, op_code(w_op), w_y};
  assign w_reject = !OP_MASK[w_op]
                  || ((w_op == 2'd3) && (w_rem != 4'd0))
                  || (NO_REPEAT && (w_exp == r_last));

  // Retry-exhaustion result: plain addition of the unswapped operands
  assign w_fb_exp = {w_a, OP_ADD, w_b};
  assign w_fb_ans = {3'b000, w_a} + {3'b000, w_b};

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_exp      <= '0;
      r_line     <= '0;
      r_answer   <= '0;
      r_fallback <= 1'b0;
      r_retry    <= '0;
      r_last     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state <= S_DRAW;
            r_busy  <= 1'b1;
            r_retry <= '0;
          end
        end
        S_DRAW: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (!w_reject) begin
            r_exp      <= w_exp;
            r_line     <= w_ln;
            r_answer   <= w_ans;
            r_fallback <= 1'b0;
            r_last     <= w_exp;
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_HOLD;
          end else if (r_retry == c_max_retry) begin
            r_exp      <= w_fb_exp;
            r_line     <= w_ln;
            r_answer   <= w_fb_ans;
            r_fallback <= 1'b1;
            r_last     <= w_fb_exp;
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_HOLD;
          end else begin
            r_retry <= r_retry + 8'd1;
            r_state <= S_DRAW;
          end
        end
        S_HOLD: begin
          // Outputs stay frozen until the consumer acknowledges
          if (ack) begin
            r_valid <= 1'b0;
            if (req) begin
              r_state <= S_DRAW;
              r_busy  <= 1'b1;
              r_retry <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign valid    = r_valid;
  assign busy     = r_busy;
  assign exp      = r_exp;
  assign line     = r_line;
  assign answer   = r_answer;
  assign fallback = r_fallback;

endmodule
`default_nettype wire
